// File: rtl/hitw_pkg.sv
// Shared definitions for the hole-in-the-wall game: game-state encoding seen
// by the pixel compositor, screen dimensions and wall-depth constants.
package hitw_pkg;

    typedef enum logic [2:0] {
        GAME_OVER        = 3'd0,
        GAME_IN_PROGRESS = 3'd1,
        GAME_WIN         = 3'd2
    } game_state_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUNNING,
        ST_OVER,
        ST_WIN
    } ctrl_state_t;

    localparam int unsigned H_ACTIVE         = 1280;
    localparam int unsigned V_ACTIVE         = 720;

    localparam int unsigned GOAL_DEPTH       = 60;
    localparam int unsigned GOAL_DEPTH_DELTA = 10;
    localparam int unsigned MAX_WALL_DEPTH   = 75;

endpackage

// File: rtl/frame_collision_accumulator.sv
// Counts collision pixels inside the active area, latches the per-frame total
// on the last active pixel and strobes frame_done_out for one cycle.
module frame_collision_accumulator
    import hitw_pkg::*;
#(
    parameter int unsigned ACTIVE_H_PIXELS = H_ACTIVE,
    parameter int unsigned ACTIVE_LINES    = V_ACTIVE
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        is_collision,
    output logic [19:0] collision_count_out,
    output logic        frame_done_out
);

    logic [19:0] acc_q, acc_d;
    logic [19:0] count_q, count_d;
    logic        done_q, done_d;
    logic        in_area, last_pixel;
    logic [19:0] acc_inc;

    // Saturating accumulate; the last active pixel folds into the latched total
    always_comb begin
        in_area    = (hcount_in < 11'(ACTIVE_H_PIXELS)) && (vcount_in < 10'(ACTIVE_LINES));
        last_pixel = (hcount_in == 11'(ACTIVE_H_PIXELS - 1)) && (vcount_in == 10'(ACTIVE_LINES - 1));
        acc_inc    = (in_area && is_collision && (acc_q != '1)) ? acc_q + 20'd1 : acc_q;
        acc_d      = acc_inc;
        count_d    = count_q;
        done_d     = 1'b0;
        if (last_pixel) begin
            count_d = acc_inc;
            acc_d   = '0;
            done_d  = 1'b1;
        end
    end

    // Accumulator, frame total and strobe registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            acc_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign collision_count_out = count_q;
    assign frame_done_out      = done_q;

endmodule

// File: rtl/game_state_controller.sv
// Game sequencer: advances the wall toward the player, judges collisions in
// the goal-depth window and steps through walls to a win.
module game_state_controller
    import hitw_pkg::*;
#(
    parameter int unsigned ACTIVE_H_PIXELS     = hitw_pkg::H_ACTIVE,
    parameter int unsigned ACTIVE_LINES        = hitw_pkg::V_ACTIVE,
    parameter int unsigned GOAL_DEPTH          = hitw_pkg::GOAL_DEPTH,
    parameter int unsigned GOAL_DEPTH_DELTA    = hitw_pkg::GOAL_DEPTH_DELTA,
    parameter int unsigned MAX_WALL_DEPTH      = hitw_pkg::MAX_WALL_DEPTH,
    parameter int unsigned FRAMES_PER_STEP     = 4,
    parameter int unsigned COLLISION_THRESHOLD = 256,
    parameter int unsigned NUM_WALLS           = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        is_collision,
    input  logic        start_in,
    output logic [2:0]  game_state_out,
    output logic [7:0]  wall_depth_out,
    output logic [1:0]  wall_index_out,
    output logic        wall_active_out,
    output logic [19:0] collision_count_out,
    output logic        frame_done_out
);

    localparam int unsigned        STEP_W    = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(FRAMES_PER_STEP - 1);
    localparam logic [8:0]         WIN_LO    = (GOAL_DEPTH > GOAL_DEPTH_DELTA) ?
                                               9'(GOAL_DEPTH - GOAL_DEPTH_DELTA) : 9'd0;
    localparam logic [8:0]         WIN_HI    = 9'(GOAL_DEPTH + GOAL_DEPTH_DELTA);
    localparam logic [8:0]         DEPTH_END = 9'(MAX_WALL_DEPTH);
    localparam logic [1:0]         LAST_WALL = 2'(NUM_WALLS - 1);
    localparam logic [19:0]        THRESH    = 20'(COLLISION_THRESHOLD);

    ctrl_state_t       state_q, state_d;
    logic [7:0]        depth_q, depth_d;
    logic [1:0]        index_q, index_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              in_window;
    logic [8:0]        depth_inc;

    frame_collision_accumulator #(
        .ACTIVE_H_PIXELS(ACTIVE_H_PIXELS),
        .ACTIVE_LINES   (ACTIVE_LINES)
    ) u_acc (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .hcount_in          (hcount_in),
        .vcount_in          (vcount_in),
        .is_collision       (is_collision),
        .collision_count_out(collision_count_out),
        .frame_done_out     (frame_done_out)
    );

    // Next-state, depth/index sequencing and state decode
    always_comb begin
        state_d         = state_q;
        depth_d         = depth_q;
        index_d         = index_q;
        step_d          = step_q;
        game_state_out  = GAME_IN_PROGRESS;
        wall_active_out = 1'b0;
        in_window       = ({1'b0, depth_q} >= WIN_LO) && ({1'b0, depth_q} <= WIN_HI);
        depth_inc       = {1'b0, depth_q} + 9'd1;

        case (state_q)
            ST_RUNNING: begin
                wall_active_out = 1'b1;
                if (frame_done_out) begin
                    // A fail freezes depth on the judged frame, so it wins over the step
                    if (in_window && (collision_count_out > THRESH)) begin
                        state_d = ST_OVER;
                    end else if (step_q == STEP_LAST) begin
                        step_d = '0;
                        if (depth_inc == DEPTH_END) begin
                            if (index_q == LAST_WALL) begin
                                state_d = ST_WIN;
                            end else begin
                                index_d = index_q + 2'd1;
                                depth_d = '0;
                            end
                        end else begin
                            depth_d = depth_inc[7:0];
                        end
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
            end
            ST_OVER: game_state_out = GAME_OVER;
            ST_WIN:  game_state_out = GAME_WIN;
            default: game_state_out = GAME_IN_PROGRESS;
        endcase

        if ((state_q != ST_RUNNING) && start_in) begin
            state_d = ST_RUNNING;
            depth_d = '0;
            index_d = '0;
            step_d  = '0;
        end
    end

    // State and wall-position registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ST_IDLE;
            depth_q <= '0;
            index_q <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            index_q <= index_d;
            step_q  <= step_d;
        end
    end

    assign wall_depth_out = depth_q;
    assign wall_index_out = index_q;

endmodule

// File: tb/tb_game_state_controller.sv
// Directed bench for game_state_controller; frames are compressed to the
// collision pixels of interest plus the last active pixel.
module tb_game_state_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] hc = 11'd1300;
    logic [9:0]  vc = 10'd0;
    logic        col = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  gstate;
    logic [7:0]  depth;
    logic [1:0]  idx;
    logic        active;
    logic [19:0] count;
    logic        done;

    logic [10:0] hc2 = 11'd63;
    logic [9:0]  vc2 = 10'd0;
    logic        col2 = 1'b0;
    logic        start2 = 1'b0;
    logic [2:0]  gstate2;
    logic [7:0]  depth2;
    logic [1:0]  idx2;
    logic        active2;
    logic [19:0] count2;
    logic        done2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    game_state_controller #(
        .FRAMES_PER_STEP    (4),
        .COLLISION_THRESHOLD(256),
        .NUM_WALLS          (3)
    ) u_dut (
        .clk_in(clk), .rst_in(rst_n), .hcount_in(hc), .vcount_in(vc),
        .is_collision(col), .start_in(start), .game_state_out(gstate),
        .wall_depth_out(depth), .wall_index_out(idx), .wall_active_out(active),
        .collision_count_out(count), .frame_done_out(done)
    );

    game_state_controller #(
        .ACTIVE_H_PIXELS(40),
        .ACTIVE_LINES   (20)
    ) u_small (
        .clk_in(clk), .rst_in(rst_n), .hcount_in(hc2), .vcount_in(vc2),
        .is_collision(col2), .start_in(start2), .game_state_out(gstate2),
        .wall_depth_out(depth2), .wall_index_out(idx2), .wall_active_out(active2),
        .collision_count_out(count2), .frame_done_out(done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pixel(input logic [10:0] h, input logic [9:0] v, input logic c);
        @(negedge clk);
        hc  = h;
        vc  = v;
        col = c;
    endtask

    // n collisions then the last active pixel; returns after the FSM has acted
    task automatic frame(input int n_coll);
        for (int i = 1; i < n_coll; i++) pixel(11'd0, 10'd0, 1'b1);
        pixel(11'd1279, 10'd719, n_coll > 0);
        pixel(11'd1300, 10'd0, 1'b0);
        @(negedge clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame(0);
    endtask

    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(gstate), 32'd1);
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_index", 32'(idx), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // first depth step after four clean frames
        pulse_start();
        chk("start_active", 32'(active), 32'd1);
        chk("start_state", 32'(gstate), 32'd1);
        frames(3);
        chk("depth_before_step", 32'(depth), 32'd0);
        pixel(11'd1279, 10'd719, 1'b0);
        pixel(11'd1300, 10'd0, 1'b0);
        chk("done_strobe", 32'(done), 32'd1);
        chk("depth_one_cycle", 32'(depth), 32'd0);
        @(negedge clk);
        chk("depth_two_cycles", 32'(depth), 32'd1);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("state_running", 32'(gstate), 32'd1);

        // 300 collisions outside the window at depth 40
        frames(156);
        chk("depth_40", 32'(depth), 32'd40);
        frame(300);
        chk("count_300_d40", 32'(count), 32'd300);
        chk("no_fail_d40", 32'(gstate), 32'd1);
        frames(3);
        chk("depth_advances_41", 32'(depth), 32'd41);

        // exactly threshold at the window edge does not fail
        frames(36);
        chk("depth_50", 32'(depth), 32'd50);
        frame(256);
        chk("count_256", 32'(count), 32'd256);
        chk("no_fail_256", 32'(gstate), 32'd1);

        // fail inside the window
        frames(3);
        frames(16);
        chk("depth_55", 32'(depth), 32'd55);
        frame(300);
        chk("fail_state", 32'(gstate), 32'd0);
        chk("fail_depth_hold", 32'(depth), 32'd55);
        chk("fail_inactive", 32'(active), 32'd0);
        chk("fail_count", 32'(count), 32'd300);
        frames(4);
        chk("over_frozen", 32'(depth), 32'd55);

        // restart from OVER; start ignored while running
        pulse_start();
        chk("restart_state", 32'(gstate), 32'd1);
        chk("restart_depth", 32'(depth), 32'd0);
        chk("restart_active", 32'(active), 32'd1);
        frames(8);
        pulse_start();
        chk("start_ignored", 32'(depth), 32'd2);

        // window boundaries 49 and 71 do not judge
        frames(188);
        chk("depth_49", 32'(depth), 32'd49);
        frame(300);
        chk("no_fail_d49", 32'(gstate), 32'd1);
        frames(3);
        frames(84);
        chk("depth_71", 32'(depth), 32'd71);
        frame(300);
        chk("no_fail_d71", 32'(gstate), 32'd1);

        // clear three walls
        frames(3);
        frames(8);
        chk("depth_74", 32'(depth), 32'd74);
        frames(4);
        chk("wall1_index", 32'(idx), 32'd1);
        chk("wall1_depth", 32'(depth), 32'd0);
        frames(300);
        chk("wall2_index", 32'(idx), 32'd2);
        chk("wall2_depth", 32'(depth), 32'd0);
        frames(299);
        chk("last_wall_running", 32'(gstate), 32'd1);
        frames(1);
        chk("win_state", 32'(gstate), 32'd2);
        chk("win_inactive", 32'(active), 32'd0);
        chk("win_depth", 32'(depth), 32'd74);
        chk("win_index", 32'(idx), 32'd2);
        frame(300);
        chk("win_not_judged", 32'(gstate), 32'd2);

        // start coincident with frame_done in WIN
        for (int i = 1; i < 300; i++) pixel(11'd0, 10'd0, 1'b1);
        pixel(11'd1279, 10'd719, 1'b1);
        @(negedge clk);
        hc = 11'd1300;
        col = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("coinc_state", 32'(gstate), 32'd1);
        chk("coinc_depth", 32'(depth), 32'd0);
        chk("coinc_index", 32'(idx), 32'd0);
        chk("coinc_count", 32'(count), 32'd300);

        // asynchronous reset mid-frame at depth 30
        frames(120);
        frame(5);
        chk("depth_30", 32'(depth), 32'd30);
        chk("count_5", 32'(count), 32'd5);
        for (int i = 0; i < 10; i++) pixel(11'd0, 10'd0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_depth", 32'(depth), 32'd0);
        chk("arst_active", 32'(active), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_state", 32'(gstate), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        hc = 11'd1300;
        col = 1'b0;
        frame(7);
        chk("post_rst_count", 32'(count), 32'd7);
        chk("post_rst_idle", 32'(active), 32'd0);

        // blanking pixels never count
        pixel(11'd1280, 10'd0, 1'b1);
        pixel(11'd0, 10'd720, 1'b1);
        pixel(11'd2047, 10'd1023, 1'b1);
        frame(2);
        chk("blank_not_counted", 32'(count), 32'd2);

        // full raster on a 40x20 screen, everything colliding
        for (int v = 0; v < 22; v++) begin
            for (int h = 0; h < 44; h++) begin
                @(negedge clk);
                hc2 = 11'(h);
                vc2 = 10'(v);
                col2 = 1'b1;
            end
        end
        @(negedge clk);
        hc2 = 11'd63;
        vc2 = 10'd0;
        col2 = 1'b0;
        chk("full_raster_count", 32'(count2), 32'd800);
        chk("small_idle_state", 32'(gstate2), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_state_controller.md
Name: game_state_controller

Overview:
- Producer side of the game-state and wall-depth interface consumed by the pixel compositor.
- Accumulates per-frame collision pixels from the is_collision stream and advances the wall toward the player once per step interval.
- Judges pass/fail inside the goal-depth window and sequences walls to a win.
- Drives game_state_out, wall_depth_out and wall_active_out for the compositor and the wall renderer.

Parameters:
ACTIVE_H_PIXELS, 1280, active pixels per line
ACTIVE_LINES, 720, active lines per frame
GOAL_DEPTH, 60, centre of the judging window
GOAL_DEPTH_DELTA, 10, half-width of the judging window (inclusive)
MAX_WALL_DEPTH, 75, depth at which a wall is cleared
FRAMES_PER_STEP, 4, frames per one-unit depth increment (≥1)
COLLISION_THRESHOLD, 256, collision pixels per frame that constitute a hit (strictly greater fails)
NUM_WALLS, 3, walls to clear for a win (1..4)

Ports:
clk_in  input  1  system/pixel clock
rst_in  input  1  asynchronous, active-low reset (0 = reset)
hcount_in  input  11  current pixel column
vcount_in  input  10  current pixel row
is_collision  input  1  current pixel is player-over-wall
start_in  input  1  single-cycle start/restart pulse (debounced upstream)
game_state_out  output  3  0=GAME_OVER, 1=GAME_IN_PROGRESS, 2=GAME_WIN
wall_depth_out  output  8  current wall depth, 0 = far
wall_index_out  output  2  index of the wall in play
wall_active_out  output  1  wall rendered this frame
collision_count_out  output  20  collision pixel total of last completed frame
frame_done_out  output  1  one-cycle strobe after frame accumulation completes

Behaviour:
- Reset (async assert, sync-release usage): FSM=IDLE, game_state_out=1, wall_depth_out=0, wall_index_out=0, wall_active_out=0, collision_count_out=0, frame_done_out=0, all internal counters 0.
- Accumulation:
  - Counts is_collision only when hcount_in<ACTIVE_H_PIXELS and vcount_in<ACTIVE_LINES.
  - Counter is 20-bit and saturates at 2^20-1.
- Frame end:
  - At the edge sampling hcount_in=ACTIVE_H_PIXELS-1, vcount_in=ACTIVE_LINES-1, collision_count_out ← accumulator plus that final pixel.
  - On the same edge the accumulator clears to 0 and frame_done_out goes high for exactly one cycle.
  - The FSM acts on the following edge, so game_state_out changes 2 cycles after the last active pixel.
- FSM states: IDLE, RUNNING, OVER, WIN.
  - IDLE: game_state_out=1, wall_active_out=0. start_in → RUNNING with depth 0, index 0, step counter 0.
  - RUNNING: wall_active_out=1. On each frame_done the step counter increments.
    - When it reaches FRAMES_PER_STEP-1 it wraps to 0 and wall_depth_out increments.
    - Fail check runs on the same frame_done. If GOAL_DEPTH-GOAL_DEPTH_DELTA ≤ wall_depth_out ≤ GOAL_DEPTH+GOAL_DEPTH_DELTA and collision_count_out > COLLISION_THRESHOLD → OVER.
    - Fail has priority over the depth step; depth holds on that frame.
    - If the increment would reach MAX_WALL_DEPTH, the wall is cleared.
      - If wall_index_out=NUM_WALLS-1 → WIN.
      - Otherwise wall_index_out increments and wall_depth_out ← 0.
  - OVER: game_state_out=0, wall_active_out=0; depth and index frozen for display. start_in → RUNNING with full restart values.
  - WIN: game_state_out=2, wall_active_out=0; depth and index frozen. start_in → RUNNING with full restart values.
- start_in while in RUNNING is ignored.
- start_in coincident with frame_done in OVER/WIN: the restart takes effect, and that frame's count is not judged.
- Collision accumulation never stops. It runs in every state.
- Reset asserted mid-frame: everything returns to reset values immediately. The partial-frame count is discarded.
- wall_depth_out never exceeds MAX_WALL_DEPTH-1.
- All widths are unsigned. The window comparison is done in 9-bit so GOAL_DEPTH-GOAL_DEPTH_DELTA cannot underflow.

Decomposition:
- Shared package hitw_pkg holds:
  - game_state_t enum: GAME_OVER=0, GAME_IN_PROGRESS=1, GAME_WIN=2 (also used by the compositor).
  - Screen-dimension constants.
  - Depth constants GOAL_DEPTH, GOAL_DEPTH_DELTA, MAX_WALL_DEPTH.
- One sub-module, frame_collision_accumulator: active-area gating, saturating counter, end-of-frame latch, and the frame_done strobe.
- FSM and depth/index logic stay in the top module.

Test Plan:
1. Reset, then start_in, then 4 frames with no collisions (FRAMES_PER_STEP=4) → wall_depth_out 0→1 two cycles after the 4th frame's last pixel; game_state_out=1 throughout.
2. Run to wall_depth_out=55 and inject 300 collision pixels in one frame → collision_count_out=300, game_state_out=0 two cycles after frame end, wall_depth_out stays 55.
3. Inject 300 collisions at depth 40, outside the window → no fail; count reported as 300; depth keeps advancing. 256 collisions at depth 50 → no fail (threshold is strict).
4. Clear 3 walls with zero collisions → wall_index_out steps 0→1→2 and depth resets to 0 each time; after the third clear, game_state_out=2 and wall_active_out=0. Then start_in → state 1, depth 0, index 0.
5. Pull rst_in low mid-frame while RUNNING at depth 30 → outputs go to reset values without waiting for a clock edge. After release, the next frame's collision_count_out counts only that frame.
6. All 1280×720 pixels colliding → collision_count_out=921600. Pixels with hcount≥1280 or vcount≥720 driven colliding are not counted.
